// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the memory-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, REQ, WAIT)
//   arb_owner_e : which requester owns the in-flight transaction
//   DEF_*       : default parameter values for mem_arbiter
//   cnt_width() : counter width able to hold 0..max_count
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    // A zero or negative count still needs a one-bit register.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// arb_timeout_cnt
// Clear/enable up-counter with a terminal-count flag, used to bound the time
// the arbiter spends waiting for a bus response.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear (dominates enable)
//   enable    : count up by one this cycle
//   terminal  : high while the count equals MAX_COUNT
// The counter holds at MAX_COUNT instead of wrapping.
// ---------------------------------------------------------------------------
module arb_timeout_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_COUNT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = cnt_width(MAX_COUNT);

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(MAX_COUNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single core memory port between instruction fetch (IFU) and
// load/store (LSU). One request is accepted at a time, replayed on the bus
// with a valid/ready handshake, and its response is routed back to the owner.
// A response timeout forces an error response so a hung bus cannot stall
// the core forever.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   ifu_req_valid/ready, ifu_addr     fetch request handshake
//   ifu_resp_valid, ifu_rdata         fetch response (1-cycle pulse)
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask     load/store request handshake
//   lsu_resp_valid, lsu_rdata         load data / store ack (1-cycle pulse)
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask     bus request (latched fields)
//   mem_resp_valid, mem_rdata         bus response
//   resp_err                          pulses with owner response on timeout
//
// Configuration:
//   MEM_ARBITER_RR_EN  defined   -> round-robin between IFU and LSU
//                      undefined -> fixed LSU-over-IFU priority
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                resp_err
);

    arb_state_e state, state_next;
    arb_owner_e owner;

    logic grant_ifu;
    logic grant_lsu;
    logic accept;
    logic timeout_hit;

    // Requester selection. Grants are only acted on in IDLE.
`ifdef MEM_ARBITER_RR_EN
    arb_owner_e last_grant;

    // On a tie, the requester that did not win last time goes first.
    assign grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));
`else
    assign grant_lsu = lsu_req_valid;
`endif
    assign grant_ifu = ifu_req_valid && !grant_lsu;
    assign accept    = (state == IDLE) && (grant_lsu || grant_ifu);

    // Timeout counter is held clear outside WAIT, so it restarts from zero
    // each time WAIT is entered; a response in the same cycle freezes it.
    arb_timeout_cnt #(
        .MAX_COUNT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != WAIT),
        .enable   ((state == WAIT) && !mem_resp_valid),
        .terminal (timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request fields are captured at accept and held stable through REQ.
    // Fetches are presented to the bus as full-word reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (accept) begin
            if (grant_lsu) begin
                owner     <= OWN_LSU;
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wdata <= lsu_wdata;
                mem_wmask <= lsu_wmask;
            end else begin
                owner     <= OWN_IFU;
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wdata <= '0;
                mem_wmask <= '1;
            end
        end
    end

`ifdef MEM_ARBITER_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_IFU;
        end else if (accept) begin
            last_grant <= grant_lsu ? OWN_LSU : OWN_IFU;
        end
    end
`endif

    // Next-state and output decode. A real response beats a timeout that
    // expires in the same cycle; responses outside WAIT are ignored.
    always_comb begin
        state_next     = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        resp_err       = 1'b0;

        case (state)
            IDLE: begin
                lsu_req_ready = grant_lsu;
                ifu_req_ready = grant_ifu;
                if (grant_lsu || grant_ifu) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (mem_resp_valid) begin
                    if (owner == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                        lsu_rdata      = mem_rdata;
                    end else begin
                        ifu_resp_valid = 1'b1;
                        ifu_rdata      = mem_rdata;
                    end
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    if (owner == OWN_LSU) begin
                        lsu_resp_valid = 1'b1;
                    end else begin
                        ifu_resp_valid = 1'b1;
                    end
                    resp_err   = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter (TIMEOUT=8). Inputs change on the
// falling edge and outputs are sampled 1 ns later, well before the next
// rising edge. Expectations honour MEM_ARBITER_RR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_rdata;
    logic          resp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .resp_err       (resp_err)
    );

    task automatic drive_idle();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    // Finishes a transaction accepted in the previous cycle: one cycle of
    // bus ready, one cycle of response, then one idle cycle.
    task automatic complete_txn(input logic [DW-1:0] data);
        @(negedge clk);
        drive_idle();
        mem_req_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        mem_resp_valid = 1'b1;
        mem_rdata      = data;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        logic [4:0] got_ctl;
        logic [AW+DW+DW+DW+4:0] got_data;
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        got_ctl = {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid};
        checks++;
        if (got_ctl !== 5'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b err=%b expected 00000 err=0", got_ctl, resp_err);
        end
        got_data = {mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata};
        checks++;
        if (got_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", got_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ifu_read();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ifu_accept: got %b expected 10", {ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready} !==
            {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'hF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ifu_bus_req: got v=%b a=%h w=%b d=%h m=%h r=%b expected v=1 a=80000000 w=0 d=0 m=f r=0",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
        end
        @(negedge clk);
        drive_idle();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0413;
        #1;
        checks++;
        if ({ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata, resp_err} !==
            {1'b1, 32'h0000_0413, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL ifu_resp: got v=%b d=%h lv=%b ld=%h e=%b expected v=1 d=00000413 lv=0 ld=0 e=0",
                     ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata, resp_err);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if ({ifu_resp_valid, mem_req_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ifu_resp_pulse: got %b expected 00", {ifu_resp_valid, mem_req_valid});
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'h3;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL prio_grant: got lsu/ifu=%b expected 10", {lsu_req_ready, ifu_req_ready});
        end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready} !==
            {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL prio_bus_req: got v=%b a=%h w=%b d=%h m=%h r=%b expected v=1 a=80001000 w=1 d=deadbeef m=3 r=0",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready);
        end
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        #1;
        checks++;
        if ({lsu_resp_valid, lsu_rdata, ifu_resp_valid, ifu_rdata, ifu_req_ready} !==
            {1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL store_ack: got lv=%b ld=%h iv=%b id=%h ir=%b expected lv=1 ld=12345678 iv=0 id=0 ir=0",
                     lsu_resp_valid, lsu_rdata, ifu_resp_valid, ifu_rdata, ifu_req_ready);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, lsu_resp_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL prio_second: got %b expected 100", {ifu_req_ready, lsu_req_ready, lsu_resp_valid});
        end
        @(negedge clk);
        drive_idle();
        mem_req_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
            {1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'hF}) begin
            errors++;
            $display("[TB] FAIL prio_ifu_req: got v=%b a=%h w=%b d=%h m=%h expected v=1 a=80000004 w=0 d=0 m=f",
                     mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        @(negedge clk);
        drive_idle();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_0001;
        #1;
        checks++;
        if ({ifu_resp_valid, ifu_rdata, lsu_resp_valid} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
            errors++;
            $display("[TB] FAIL prio_ifu_resp: got v=%b d=%h lv=%b expected v=1 d=cafe0001 lv=0",
                     ifu_resp_valid, ifu_rdata, lsu_resp_valid);
        end
        @(negedge clk);
        drive_idle();
    endtask

    // Tie immediately after an LSU grant: fixed priority still picks LSU,
    // round-robin picks IFU.
    task automatic test_round_robin();
        logic [1:0] exp_rdy;
`ifdef MEM_ARBITER_RR_EN
        exp_rdy = 2'b01;
`else
        exp_rdy = 2'b10;
`endif
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0100;
        complete_txn(32'h0);
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0008;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0104;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_req_ready} !== exp_rdy) begin
            errors++;
            $display("[TB] FAIL tie_after_lsu: got lsu/ifu=%b expected %b", {lsu_req_ready, ifu_req_ready}, exp_rdy);
        end
        complete_txn(32'h0);
    endtask

    task automatic test_stall();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            lsu_req_valid = 1'b1;
            lsu_addr      = 32'h0000_0200 + 32'(i);
            lsu_wen       = 1'b1;
            lsu_wmask     = 4'h1;
            mem_req_ready = 1'b0;
            #1;
            checks++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready} !==
                {1'b1, 32'h8000_0040, 1'b0, 4'hF, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_%0d: got v=%b a=%h w=%b m=%h ir=%b lr=%b expected v=1 a=80000040 w=0 m=f ir=0 lr=0",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready);
            end
        end
        complete_txn(32'h0);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0080;
        @(negedge clk);
        drive_idle();
        mem_req_ready = 1'b1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid, resp_err} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL timeout_early_%0d: got %b expected 000", k, {ifu_resp_valid, lsu_resp_valid, resp_err});
            end
        end
        @(negedge clk);
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({ifu_resp_valid, resp_err, ifu_rdata, lsu_resp_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got v=%b e=%b d=%h lv=%b expected v=1 e=1 d=0 lv=0",
                     ifu_resp_valid, resp_err, ifu_rdata, lsu_resp_valid);
        end
        @(negedge clk);
        drive_idle();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0300;
        #1;
        checks++;
        if ({lsu_req_ready, ifu_resp_valid, resp_err} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL timeout_idle: got %b expected 100", {lsu_req_ready, ifu_resp_valid, resp_err});
        end
        @(negedge clk);
        drive_idle();
        mem_req_ready = 1'b1;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            drive_idle();
        end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hA5A5_A5A5;
        #1;
        checks++;
        if ({lsu_resp_valid, resp_err, lsu_rdata} !== {1'b1, 1'b0, 32'hA5A5_A5A5}) begin
            errors++;
            $display("[TB] FAIL timeout_tie: got v=%b e=%b d=%h expected v=1 e=0 d=a5a5a5a5",
                     lsu_resp_valid, resp_err, lsu_rdata);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0400;
        @(negedge clk);
        drive_idle();
        mem_req_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr, lsu_resp_valid, ifu_resp_valid, resp_err} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b a=%h lv=%b iv=%b e=%b expected all 0",
                     mem_req_valid, mem_addr, lsu_resp_valid, ifu_resp_valid, resp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0BAD;
        #1;
        checks++;
        if ({lsu_resp_valid, ifu_resp_valid, resp_err, lsu_rdata, ifu_rdata} !== '0) begin
            errors++;
            $display("[TB] FAIL late_resp: got lv=%b iv=%b e=%b ld=%h id=%h expected all 0",
                     lsu_resp_valid, ifu_resp_valid, resp_err, lsu_rdata, ifu_rdata);
        end
        @(negedge clk);
        drive_idle();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        #1;
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_accept: got %b expected 1", ifu_req_ready);
        end
        @(negedge clk);
        drive_idle();
        mem_req_ready = 1'b1;
        @(negedge clk);
        drive_idle();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0055;
        #1;
        checks++;
        if ({ifu_resp_valid, ifu_rdata} !== {1'b1, 32'h0000_0055}) begin
            errors++;
            $display("[TB] FAIL post_reset_resp: got v=%b d=%h expected v=1 d=00000055", ifu_resp_valid, ifu_rdata);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_data;
        logic [AW-1:0] addr;
        int            ready_dly;
        int            resp_dly;
        for (int i = 0; i < 100; i++) begin
            addr      = 32'h8000_0000 + 32'(i * 4);
            exp_data  = $urandom;
            ready_dly = $urandom_range(0, 3);
            resp_dly  = $urandom_range(0, 4);
            @(negedge clk);
            drive_idle();
            ifu_req_valid = 1'b1;
            ifu_addr      = addr;
            #1;
            checks++;
            if (ifu_req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_accept_%0d: got %b expected 1", i, ifu_req_ready);
            end
            for (int d = 0; d < ready_dly; d++) begin
                @(negedge clk);
                drive_idle();
            end
            @(negedge clk);
            drive_idle();
            mem_req_ready = 1'b1;
            #1;
            checks++;
            if ({mem_req_valid, mem_addr} !== {1'b1, addr}) begin
                errors++;
                $display("[TB] FAIL b2b_req_%0d: got v=%b a=%h expected v=1 a=%h", i, mem_req_valid, mem_addr, addr);
            end
            for (int d = 0; d < resp_dly; d++) begin
                @(negedge clk);
                drive_idle();
            end
            @(negedge clk);
            drive_idle();
            mem_resp_valid = 1'b1;
            mem_rdata      = exp_data;
            #1;
            checks++;
            if ({ifu_resp_valid, ifu_rdata, lsu_resp_valid, resp_err} !== {1'b1, exp_data, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL b2b_resp_%0d: got v=%b d=%h lv=%b e=%b expected v=1 d=%h lv=0 e=0",
                         i, ifu_resp_valid, ifu_rdata, lsu_resp_valid, resp_err, exp_data);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_priority();
        test_round_robin();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single core memory port between instruction fetch (IFU) and load/store (LSU).
- Accepts one request at a time, replays it on the memory bus with a valid/ready handshake, and routes the response back to the owner.
- Includes a response timeout so a hung bus cannot deadlock the core.
- Sits between the IFU/LSU request interfaces and the memory/DPI bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum WAIT cycles before an error response is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted this cycle
- lsu_addr  in  ADDR_W  data address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_resp_valid  out  1  load data / store ack (1-cycle pulse)
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  latched request
- mem_resp_valid  in  1  bus response
- mem_rdata  in  DATA_W  bus read data
- resp_err  out  1  pulses with owner resp_valid on timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; owner = IFU; timeout counter 0.
- FSM has three states: IDLE, REQ, WAIT.
- IDLE:
  - Selects a requester; fixed priority is LSU over IFU.
  - Asserts the selected *_req_ready combinationally in the same cycle as its valid.
  - Latches addr/wen/wdata/wmask (IFU: wen=0, wmask=all-ones, wdata=0) and the owner; goes to REQ.
  - With no request, stays in IDLE.
- REQ:
  - Holds mem_req_valid=1 with stable latched fields until mem_req_ready=1, then goes to WAIT.
  - No *_req_ready is asserted in REQ or WAIT.
- WAIT:
  - On mem_resp_valid, drives owner resp_valid=1 and rdata=mem_rdata combinationally for that cycle (stores also pulse resp_valid), then returns to IDLE.
  - The non-owner resp_valid stays 0; its rdata holds 0.
- Timeout:
  - Counter clears on entering WAIT and increments each WAIT cycle without a response.
  - When it reaches TIMEOUT: owner resp_valid=1, rdata=0, resp_err=1 for one cycle; go to IDLE.
  - A response arriving in the same cycle wins and resp_err stays 0.
- Stray responses: mem_resp_valid in IDLE or REQ is ignored (no pulse, no state change).
- Latency:
  - Accept at cycle N, mem_req_valid from N+1.
  - With ready at N+1 and response at N+2, owner resp at N+2; next accept possible at N+3.
  - Minimum 3 cycles per transaction.
- Reset mid-transaction: immediate return to IDLE; the pending response is dropped, and a late mem_resp_valid is ignored per the rule above.
- A requester may drop valid while not granted; no side effects.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. A one-bit last_grant register, reset to IFU, updates on each accept.
- Undefined: fixed LSU-over-IFU priority; no last_grant register exists.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_e {IDLE, REQ, WAIT}
  - enum arb_owner_e {OWN_IFU, OWN_LSU}
  - localparam defaults for ADDR_W/DATA_W/TIMEOUT
- One natural sub-module: arb_timeout_cnt, a clear/enable counter with a terminal-count flag of width $clog2(TIMEOUT+1).
- The selection logic stays inline.

Test Plan:
- IFU-only read, addr 0x80000000, bus ready immediately, response next cycle with rdata 0x00000413 -> ifu_resp_valid at accept+2 with 0x00000413; mem_wen=0, wmask=0xF.
- Simultaneous IFU and LSU requests (LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x3) -> LSU granted first, mem_* matches exactly; IFU granted on the next IDLE. With MEM_ARBITER_RR_EN and last grant LSU, IFU wins instead.
- mem_req_ready held low 5 cycles -> mem_req_valid and fields stable all 5 cycles; no ready to either requester.
- No response after the grant, TIMEOUT=8 -> owner resp_valid and resp_err pulse exactly 8 WAIT cycles after entry, rdata=0; back to IDLE.
- rst asserted during WAIT, then mem_resp_valid arrives 2 cycles after release -> no resp_valid pulse; outputs 0; next request handled normally.
- Back-to-back IFU requests, 100 transactions with random ready/response delays -> each response is routed to IFU only, in order, with correct data.
